ccip_c1_write_shaper: RTL
=========================

// Module: ccip_c1_write_shaper
// PURPOSE
// - Sits between the CCI-P transmitter's sTx_c1 output and the FIU C1 TX channel.
// - Buffers WRLINE_I beats in a FIFO and holds back new bursts while sRx_c1TxAlmFull is high.
// - Issues each 1/2/4-CL burst atomically, on back-to-back cycles.
// - Catches overflow and malformed bursts, and raises a sticky error.
// PARAMETERS
// - NIC_ID       0   NIC index; used only in $display messages.
// - LFIFO_DEPTH  5   log2 of beat FIFO depth (32 entries). Must be >= 3.
// PORTS
// - clk               in   1       clock
// - reset             in   1       reset, synchronous, active-high
// - sTx_c1_in         in   t_if_ccip_c1_Tx   beats from the transmitter; .valid qualifies the beat
// - sRx_c1TxAlmFull   in   1       FIU C1 almost-full
// - sTx_c1            out  t_if_ccip_c1_Tx   beats to the FIU; registered
// - in_ready          out  1       1 when free entries >= 4
// - fifo_level        out  LFIFO_DEPTH+1     current FIFO occupancy
// - drop_out          out  1       one-cycle pulse when a beat is discarded
// - error             out  1       sticky; cleared only by reset
// - stall_cycles_out  out  32      cycles in S_IDLE with a complete burst blocked by AlmFull
// - beats_issued_out  out  32      count of beats driven out with valid
// BEHAVIOUR
// - Reset values: sTx_c1.valid=0; sTx_c1.hdr=0; in_ready=1; fifo_level=0; drop_out=0;
//   error=0; both counters=0. State = S_IDLE, beat counter = 0.
// - Reset mid-burst: the burst is abandoned, the FIFO is emptied, and sTx_c1.valid=0 the next cycle.
// - Push: when sTx_c1_in.valid=1 and the FIFO is not full, {hdr,data} is written.
// - Overflow: if the FIFO is full, the beat is dropped, drop_out pulses next cycle, and error is set.
// - Simultaneous push and pop: allowed. Occupancy is unchanged. When the FIFO is full, a push in
//   the same cycle as a pop is accepted.
// - Burst length from head hdr.cl_len:
//   - eCL_LEN_1 -> 1
//   - eCL_LEN_2 -> 2
//   - eCL_LEN_4 -> 4
//   - Encoding 2'b10 is illegal: error is set and the burst is treated as length 1.
// - FSM S_IDLE:
//   - Head valid with hdr.sop=1, occupancy >= burst length, and sRx_c1TxAlmFull=0:
//     pop the head, latch burst length, set beat counter to 1, go to S_BURST.
//     If the burst length is 1, stay in S_IDLE.
//   - Head valid with sop=0 (orphan beat): pop and discard it, set error, pulse drop_out.
//   - Any other case: hold.
// - FSM S_BURST: pop one beat per cycle regardless of AlmFull, then increment the beat counter.
//   - When the beat counter reaches burst length - 1 on a pop, return to S_IDLE.
//   - A non-first beat with sop=1 is still issued, and error is set.
//   - Occupancy was checked at burst start, so the FIFO never underflows mid-burst.
// - AlmFull is sampled only at burst start. The FIU guarantees >= 8 slots of slack, which covers
//   one 4-CL burst.
// - Latency: a popped beat appears on sTx_c1 with valid=1 exactly 1 cycle after the pop. A single
//   beat pushed into an empty FIFO with AlmFull low appears 2 cycles after its input cycle.
// - Output content: hdr and data are passed through unmodified.
//   - sTx_c1.valid=0 on non-issue cycles.
//   - hdr and data hold their last value on non-issue cycles.
// - in_ready: combinational from registered occupancy: (2**LFIFO_DEPTH - fifo_level) >= 4.
// - Counters: 32-bit and wrap modulo 2**32.
// CONFIGURATION
// - C1_SHAPER_STATS_EN defined:
//   - stall_cycles_out increments each cycle that S_IDLE holds a complete sop burst only because
//     AlmFull=1.
//   - beats_issued_out increments per issued beat.
//   - Both are registered.
// - C1_SHAPER_STATS_EN undefined:
//   - Both ports are tied to 0 and no counter flops are instantiated.
//   - All other behaviour is identical.
// TESTING
// - T1 single-beat: push 1 beat, sop=1, cl_len=eCL_LEN_1, addr=0x100, AlmFull=0
//   -> sTx_c1.valid exactly 2 cycles after push; addr=0x100.
// - T2 4-CL burst: push 4 beats, cl_len=eCL_LEN_4, addr 0x200..0x203, spaced 3 cycles apart
//   -> no output until the 4th beat is pushed; then 4 consecutive valid cycles, addr 0x200..0x203,
//      sop only on the first.
// - T3 AlmFull hold: AlmFull=1 with a complete 2-CL burst queued for 10 cycles, then AlmFull=0
//   -> no valid during the hold; then 2 back-to-back beats.
//   -> With C1_SHAPER_STATS_EN: stall_cycles_out=10.
// - T4 AlmFull mid-burst: 4-CL burst started, AlmFull rises after beat 1
//   -> beats 2..4 are still issued on consecutive cycles.
// - T5 overflow: LFIFO_DEPTH=3, AlmFull=1, push 9 single-beat sop beats
//   -> the 9th beat is dropped; drop_out pulses once; error=1; fifo_level=8; in_ready=0.
// - T6 orphan and reset: push a beat with sop=0 in S_IDLE -> discarded, error=1.
//   - Then start a 4-CL burst and assert reset after beat 2.
//   - Required: valid=0 the next cycle, fifo_level=0, error=0.

Source files
------------

// File: rtl/ccip_c1_write_shaper.sv
// CCI-P C1 write shaper: buffers WRLINE beats and issues 1/2/4-CL bursts atomically.
// Optional `C1_SHAPER_STATS_EN enables the stall and issued-beat counters.
package ccip_c1_shaper_pkg;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef struct packed {
    logic [5:0]  rsvd1;
    logic [1:0]  vc_sel;
    logic        sop;
    logic        rsvd0;
    t_ccip_clLen cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd2;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

endpackage

module ccip_c1_write_shaper
  import ccip_c1_shaper_pkg::*;
#(
  parameter int unsigned NIC_ID      = 0,
  parameter int unsigned LFIFO_DEPTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  t_if_ccip_c1_Tx       sTx_c1_in,
  input  logic                 sRx_c1TxAlmFull,
  output t_if_ccip_c1_Tx       sTx_c1,
  output logic                 in_ready,
  output logic [LFIFO_DEPTH:0] fifo_level,
  output logic                 drop_out,
  output logic                 error,
  output logic [31:0]          stall_cycles_out,
  output logic [31:0]          beats_issued_out
);

  localparam int unsigned Depth = 2 ** LFIFO_DEPTH;
  localparam logic [LFIFO_DEPTH:0] DepthW  = (LFIFO_DEPTH + 1)'(Depth);
  localparam logic [LFIFO_DEPTH:0] MinFree = (LFIFO_DEPTH + 1)'(4);

  if (LFIFO_DEPTH < 3) begin : g_param_check
    $error("ccip_c1_write_shaper NIC %0d: LFIFO_DEPTH must be >= 3", NIC_ID);
  end

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
  } t_beat;

  typedef enum logic {StIdle, StBurst} t_state;

  t_beat                  mem_q [Depth];
  logic [LFIFO_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LFIFO_DEPTH:0]   count_q, count_d;
  t_state                 state_q, state_d;
  logic [1:0]             beat_cnt_q, beat_cnt_d;
  logic [1:0]             last_q, last_d;
  t_if_ccip_c1_Tx         out_q, out_d;
  logic                   drop_q, drop_d;
  logic                   error_q, error_d;

  t_beat      head;
  logic       head_valid, head_complete, head_illegal;
  logic [2:0] head_len;
  logic [1:0] head_last;
  logic       full, pop, issue, push, overflow, orphan, set_err;

  always_comb begin
    head         = mem_q[rd_ptr_q];
    head_valid   = (count_q != '0);
    head_illegal = 1'b0;
    case (head.hdr.cl_len)
      eCL_LEN_1: begin head_len = 3'd1; head_last = 2'd0; end
      eCL_LEN_2: begin head_len = 3'd2; head_last = 2'd1; end
      eCL_LEN_4: begin head_len = 3'd4; head_last = 2'd3; end
      default: begin
        // Illegal encoding degrades to a single beat.
        head_len     = 3'd1;
        head_last    = 2'd0;
        head_illegal = 1'b1;
      end
    endcase
    head_complete = head_valid && (count_q >= (LFIFO_DEPTH + 1)'(head_len));
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    pop        = 1'b0;
    issue      = 1'b0;
    orphan     = 1'b0;
    set_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (head_valid && !head.hdr.sop) begin
          pop    = 1'b1;
          orphan = 1'b1;
        end else if (head_complete && !sRx_c1TxAlmFull) begin
          pop        = 1'b1;
          issue      = 1'b1;
          set_err    = head_illegal;
          last_d     = head_last;
          beat_cnt_d = 2'd1;
          if (head_last != 2'd0) state_d = StBurst;
        end
      end
      StBurst: begin
        // Occupancy was checked at burst start, so the head is always valid here.
        pop        = 1'b1;
        issue      = 1'b1;
        set_err    = head.hdr.sop;
        beat_cnt_d = beat_cnt_q + 2'd1;
        if (beat_cnt_q == last_q) begin
          state_d    = StIdle;
          beat_cnt_d = 2'd0;
        end
      end
    endcase
  end

  always_comb begin
    full     = (count_q == DepthW);
    push     = sTx_c1_in.valid && (!full || pop);
    overflow = sTx_c1_in.valid && full && !pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    out_d       = out_q;
    out_d.valid = 1'b0;
    if (issue) begin
      out_d.valid = 1'b1;
      out_d.hdr   = head.hdr;
      out_d.data  = head.data;
    end
    drop_d  = overflow || orphan;
    error_d = error_q || overflow || orphan || set_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      last_q     <= '0;
      out_q      <= '0;
      drop_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      error_q    <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{hdr: sTx_c1_in.hdr, data: sTx_c1_in.data};
  end

  assign sTx_c1     = out_q;
  assign fifo_level = count_q;
  assign in_ready   = (DepthW - count_q) >= MinFree;
  assign drop_out   = drop_q;
  assign error      = error_q;

`ifdef C1_SHAPER_STATS_EN
  logic [31:0] stall_q, issued_q;
  logic        stall;

  // Blocked solely by AlmFull: a complete sop burst is at the head in idle.
  assign stall = (state_q == StIdle) && head_complete && head.hdr.sop && sRx_c1TxAlmFull;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      if (stall) stall_q  <= stall_q + 32'd1;
      if (issue) issued_q <= issued_q + 32'd1;
    end
  end

  assign stall_cycles_out = stall_q;
  assign beats_issued_out = issued_q;
`else
  assign stall_cycles_out = '0;
  assign beats_issued_out = '0;
`endif

endmodule
